// File: rtl/rom_pixel_streamer.sv
// rom_pixel_streamer: credit-paced ROM reader feeding a 2-entry valid/ready pixel stream
module rom_pixel_streamer #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   pix_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic                  pix_valid_o,
    output logic                  pix_last_o,
    input  logic                  pix_ready_i
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic                  r_pend, r_pend_last, r_done, r_wr, r_rd;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH:0]   r_mem [2];
    logic [DATA_WIDTH:0]   w_head;
    logic [1:0]            w_credit;
    logic                  w_pop, w_issue, w_final, w_flush, w_last_pop, w_load;
    assign w_head      = r_mem[r_rd];
    assign pix_valid_o = r_occ != 2'd0;
    assign pix_data_o  = w_head[DATA_WIDTH-1:0];
    assign pix_last_o  = pix_valid_o && w_head[DATA_WIDTH];
    assign busy_o      = r_state != IDLE;
    assign done_o      = r_done;
    assign rom_addr_o  = r_addr;
    assign w_pop       = pix_valid_o && pix_ready_i;
    // slots already committed after this edge: buffered + in flight - leaving
    assign w_credit    = r_occ + 2'(r_pend) - 2'(w_pop);
    assign w_issue     = r_state == RUN && r_remain != '0 && w_credit < 2'd2;
    assign w_final     = w_issue && r_remain == (ADDR_WIDTH+1)'(1);
    assign w_flush     = abort_i && r_state != IDLE;
    assign w_last_pop  = w_pop && w_head[DATA_WIDTH];
    assign w_load      = r_state == IDLE && start_i && pix_count_i != '0;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_load ? RUN : IDLE;
            RUN:     w_next = abort_i ? IDLE : (w_final ? DRAIN : RUN);
            DRAIN:   w_next = (abort_i || w_last_pop) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_done      <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_occ       <= 2'd0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
        end else begin
            r_done <= (r_state == IDLE && start_i && pix_count_i == '0) ||
                      (r_state == DRAIN && !abort_i && w_last_pop);
            if (w_load) begin
                r_addr   <= base_addr_i;
                r_remain <= pix_count_i;
            end else if (w_issue && !w_flush) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_remain <= r_remain - (ADDR_WIDTH+1)'(1);
            end
            r_pend      <= w_issue && !w_flush;
            r_pend_last <= w_final;
            if (w_flush) begin
                r_occ <= 2'd0;
                r_wr  <= 1'b0;
                r_rd  <= 1'b0;
            end else begin
                if (r_pend) begin
                    r_mem[r_wr] <= {r_pend_last, rom_data_i};
                    r_wr        <= ~r_wr;
                end
                if (w_pop) r_rd <= ~r_rd;
                r_occ <= w_credit;
            end
        end
    end
endmodule

// File: tb/tb_rom_pixel_streamer.sv
// tb_rom_pixel_streamer: directed scenarios against a synchronous ROM model holding ROM[a]=a[15:0]
module tb_rom_pixel_streamer;
    logic        clk = 1'b0;
    logic        rst_n, start_i, abort_i, pix_ready_i;
    logic [16:0] base_addr_i;
    logic [17:0] pix_count_i;
    logic        busy_o, done_o, pix_valid_o, pix_last_o;
    logic [16:0] rom_addr_o;
    logic [15:0] rom_data, pix_data_o;
    logic [5:0]  pat = 6'b101001;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_data <= rom_addr_o[15:0];

    rom_pixel_streamer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .pix_count_i(pix_count_i),
        .busy_o(busy_o), .done_o(done_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
        .pix_last_o(pix_last_o), .pix_ready_i(pix_ready_i)
    );

    task automatic do_start(input logic [16:0] base, input logic [17:0] cnt);
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; pix_count_i = cnt;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic collect(input int n, input logic [15:0] first, input bit toggle);
        int k = 0;
        bit held = 0;
        bit fin = 0;
        logic [15:0] hd = '0;
        logic [15:0] exp_d;
        logic hl = 1'b0;
        logic exp_l;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            pix_ready_i = toggle ? pat[c % 6] : 1'b1;
            if (held) begin
                vectors++;
                if (pix_valid_o !== 1'b1 || pix_data_o !== hd || pix_last_o !== hl) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             pix_valid_o, pix_data_o, pix_last_o, hd, hl);
                end
            end
            if (done_o === 1'b1) begin
                vectors++;
                fin = 1;
                if (k != n || pix_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_timing: pixels=%0d valid=%b, want pixels=%0d valid=0", k, pix_valid_o, n);
                end
            end
            if (pix_valid_o && pix_ready_i) begin
                vectors++;
                exp_d = first + 16'(k);
                exp_l = (k == n - 1);
                if (pix_data_o !== exp_d || pix_last_o !== exp_l || k >= n) begin
                    miscompares++;
                    $display("FAIL pixel[%0d]: data=%h last=%b, want data=%h last=%b", k, pix_data_o, pix_last_o, exp_d, exp_l);
                end
                k++;
            end
            held = pix_valid_o && !pix_ready_i;
            hd = pix_data_o;
            hl = pix_last_o;
        end
        vectors++;
        if (!fin || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end: done_seen=%b busy=%b, want done_seen=1 busy=0", fin, busy_o);
        end
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b0 || pix_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b valid=%b, want done=0 valid=0", done_o, pix_valid_o);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || pix_valid_o !== 1'b0 || pix_last_o !== 1'b0 ||
            rom_addr_o !== 17'h0 || pix_data_o !== 16'h0) begin
            miscompares++;
            $display("FAIL %s: busy=%b done=%b valid=%b last=%b addr=%h data=%h, want all zero",
                     name, busy_o, done_o, pix_valid_o, pix_last_o, rom_addr_o, pix_data_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; pix_ready_i = 1'b1;
        base_addr_i = '0; pix_count_i = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic test_basic;
        pix_ready_i = 1'b1;
        do_start(17'h00010, 18'd4);
        @(negedge clk);
        vectors++;
        if (busy_o !== 1'b1 || pix_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_e0: busy=%b valid=%b, want busy=1 valid=0", busy_o, pix_valid_o);
        end
        @(negedge clk);
        vectors++;
        if (pix_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_e1: valid=%b, want 0", pix_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (pix_valid_o !== 1'b1 || pix_data_o !== 16'(16 + i) || pix_last_o !== (i == 3) ||
                done_o !== 1'b0 || busy_o !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_pix%0d: valid=%b data=%h last=%b done=%b busy=%b, want 1 %h %b 0 1",
                         i, pix_valid_o, pix_data_o, pix_last_o, done_o, busy_o, 16'(16 + i), (i == 3));
            end
        end
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || pix_valid_o !== 1'b0 || rom_addr_o !== 17'h00014) begin
            miscompares++;
            $display("FAIL basic_done: done=%b busy=%b valid=%b addr=%h, want 1 0 0 00014",
                     done_o, busy_o, pix_valid_o, rom_addr_o);
        end
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_clear: done=%b, want 0", done_o);
        end
    endtask

    task automatic test_backpressure;
        do_start(17'h00100, 18'd8);
        collect(8, 16'h0100, 1'b1);
        pix_ready_i = 1'b1;
    endtask

    task automatic test_wrap;
        do_start(17'h1FFFE, 18'd4);
        collect(4, 16'hFFFE, 1'b0);
        vectors++;
        if (rom_addr_o !== 17'h00002) begin
            miscompares++;
            $display("FAIL wrap_addr: addr=%h, want 00002", rom_addr_o);
        end
    endtask

    task automatic test_zero_count;
        do_start(17'h00055, 18'd0);
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || pix_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: done=%b busy=%b valid=%b, want 1 0 0", done_o, busy_o, pix_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || pix_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_quiet%0d: done=%b busy=%b valid=%b, want 0 0 0", i, done_o, busy_o, pix_valid_o);
            end
        end
        do_start(17'h00020, 18'd2);
        collect(2, 16'h0020, 1'b0);
    endtask

    task automatic test_abort;
        int k = 0;
        pix_ready_i = 1'b1;
        do_start(17'h00040, 18'd16);
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            if (pix_valid_o && pix_ready_i) begin
                vectors++;
                if (pix_data_o !== 16'(16'h0040 + k)) begin
                    miscompares++;
                    $display("FAIL abort_pix%0d: data=%h, want %h", k, pix_data_o, 16'(16'h0040 + k));
                end
                k++;
            end
        end
        @(posedge clk);
        #1 pix_ready_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (k != 3 || pix_valid_o !== 1'b1 || pix_data_o !== 16'h0043 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_stall: pops=%0d valid=%b data=%h busy=%b, want 3 1 0043 1", k, pix_valid_o, pix_data_o, busy_o);
        end
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (pix_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_flush: valid=%b busy=%b done=%b, want 0 0 0", pix_valid_o, busy_o, done_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done_o !== 1'b0 || pix_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet%0d: done=%b valid=%b, want 0 0", i, done_o, pix_valid_o);
            end
        end
        pix_ready_i = 1'b1;
        do_start(17'h00000, 18'd2);
        collect(2, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid;
        pix_ready_i = 1'b0;
        do_start(17'h00080, 18'd8);
        repeat (5) @(negedge clk);
        vectors++;
        if (pix_valid_o !== 1'b1 || pix_data_o !== 16'h0080 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_full: valid=%b data=%h busy=%b, want 1 0080 1", pix_valid_o, pix_data_o, busy_o);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("rstmid_outputs");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("rstmid_quiet");
        end
        pix_ready_i = 1'b1;
    endtask

    task automatic test_start_while_busy;
        pix_ready_i = 1'b1;
        do_start(17'h00200, 18'd6);
        do_start(17'h00300, 18'd3);
        collect(6, 16'h0200, 1'b0);
        vectors++;
        if (rom_addr_o !== 17'h00206) begin
            miscompares++;
            $display("FAIL busy_start_addr: addr=%h, want 00206", rom_addr_o);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_zero_count;
        test_abort;
        test_reset_mid;
        test_start_while_busy;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
